// File: rtl/mips_cpu_pkg.sv
// Shared CPU types: instruction decode enums plus the memory arbiter's
// state and grant encodings.
package mips_cpu_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDIU = 6'h09,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } opcode_t;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h00,
    FN_JR   = 6'h08,
    FN_ADDU = 6'h21,
    FN_SUBU = 6'h23,
    FN_AND  = 6'h24,
    FN_OR   = 6'h25
  } funct_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

  localparam logic [3:0] BE_WORD = 4'hF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Requester-side and memory-side bundles of the CPU memory arbiter.
//
// Handshake semantics: a requester raises *_req with stable attributes and
// holds it until its one-cycle *_ack; the bus side holds read/write and all
// attributes while waitrequest is high, and a transfer completes on the
// clock edge where the strobe is high and waitrequest is low.
interface mips_cpu_req_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_err;
  logic        stall;

  modport master (
    output i_req, i_addr, d_req, d_write, d_addr, d_wdata, d_byteenable,
    input  i_rdata, i_ack, d_rdata, d_ack, bus_err, stall
  );

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_addr, d_wdata, d_byteenable,
    output i_rdata, i_ack, d_rdata, d_ack, bus_err, stall
  );
endinterface

interface mips_cpu_bus_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_cpu_mem_arbiter_wait_timer.sv
// Saturating waitrequest counter; expired fires on the wait cycle that
// brings the count up to WAIT_TIMEOUT (never when WAIT_TIMEOUT is 0).
module mips_cpu_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int unsigned CW        = (WAIT_TIMEOUT > 255) ? $clog2(WAIT_TIMEOUT + 1) : 8;
  localparam int unsigned LIMIT_INT = (WAIT_TIMEOUT == 0) ? 0 : WAIT_TIMEOUT - 1;
  localparam logic [CW-1:0] LIMIT   = LIMIT_INT[CW-1:0];
  localparam bit ENABLED            = (WAIT_TIMEOUT != 0);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // count holds the waits already seen, so this tick is wait number count+1
  assign expired = ENABLED && tick && (count >= LIMIT);

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-style master between the CPU's
// instruction-fetch and load/store requesters.
module mips_cpu_mem_arbiter
  import mips_cpu_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  mips_cpu_req_if.slave   cpu,
  mips_cpu_bus_if.master  mem,
  output arb_state_t      dbg_state,
  output grant_t          dbg_grant
);

  arb_state_t state;
  grant_t     grant;
  grant_t     last_grant;
  grant_t     winner;
  logic       start;
  logic       wait_tick;
  logic       expired;

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    winner = INSTR;
    if (cpu.i_req && cpu.d_req) begin
      winner = (last_grant == INSTR) ? DATA : INSTR;
    end else if (cpu.d_req) begin
      winner = DATA;
    end
  end

  assign start     = (state == IDLE) && (cpu.i_req || cpu.d_req);
  assign wait_tick = (state == BUS) && mem.waitrequest;

  mips_cpu_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (start),
    .tick    (wait_tick),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      grant          <= INSTR;
      last_grant     <= INSTR;
      mem.address    <= '0;
      mem.read       <= 1'b0;
      mem.write      <= 1'b0;
      mem.writedata  <= '0;
      mem.byteenable <= '0;
      cpu.i_rdata    <= '0;
      cpu.d_rdata    <= '0;
      cpu.i_ack      <= 1'b0;
      cpu.d_ack      <= 1'b0;
      cpu.bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            grant <= winner;
            state <= BUS;
            if (winner == DATA) begin
              mem.address    <= word_align(cpu.d_addr);
              mem.read       <= !cpu.d_write;
              mem.write      <= cpu.d_write;
              mem.writedata  <= cpu.d_wdata;
              mem.byteenable <= cpu.d_byteenable;
            end else begin
              mem.address    <= word_align(cpu.i_addr);
              mem.read       <= 1'b1;
              mem.write      <= 1'b0;
              mem.writedata  <= '0;
              mem.byteenable <= BE_WORD;
            end
          end
        end

        BUS: begin
          if (!mem.waitrequest) begin
            mem.read   <= 1'b0;
            mem.write  <= 1'b0;
            last_grant <= grant;
            if (mem.read) begin
              if (grant == DATA) cpu.d_rdata <= mem.readdata;
              else               cpu.i_rdata <= mem.readdata;
            end
            cpu.i_ack   <= (grant == INSTR);
            cpu.d_ack   <= (grant == DATA);
            cpu.bus_err <= 1'b0;
            state       <= DONE;
          end else if (expired) begin
            mem.read  <= 1'b0;
            mem.write <= 1'b0;
            if (grant == DATA) cpu.d_rdata <= '0;
            else               cpu.i_rdata <= '0;
            cpu.i_ack   <= (grant == INSTR);
            cpu.d_ack   <= (grant == DATA);
            cpu.bus_err <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          cpu.i_ack   <= 1'b0;
          cpu.d_ack   <= 1'b0;
          cpu.bus_err <= 1'b0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign cpu.stall = (cpu.i_req | cpu.d_req) & ~(cpu.i_ack | cpu.d_ack);
  assign dbg_state = state;
  assign dbg_grant = grant;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Randomized bench for mips_cpu_mem_arbiter: transaction-level reference model
// predicts bus order, strobe lengths and ack payloads per round.
module tb_mips_cpu_mem_arbiter;
  import mips_cpu_pkg::*;

  localparam int TMO = 4;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  arb_state_t dbg_state;
  grant_t     dbg_grant;

  mips_cpu_req_if cpu();
  mips_cpu_bus_if mem();

  mips_cpu_mem_arbiter #(.WAIT_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu       (cpu),
    .mem       (mem),
    .dbg_state (dbg_state),
    .dbg_grant (dbg_grant)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  req_t        iq[$];
  req_t        dq[$];
  logic [77:0] exp_q[$];   // {len[7:0], port, write, addr[31:0], be[3:0], wdata[31:0]}
  logic [33:0] ack_q[$];   // {port, err, rdata[31:0]}
  logic [39:0] plan_q[$];  // {waits[7:0], readdata[31:0]}
  logic [31:0] rdata_m [2];
  bit          last_data_m;

  int          cycle;
  int          exp_start;
  int          strobe_len;
  int          wait_cnt;
  logic        prev_strobe;
  logic [77:0] cur;
  logic [69:0] held;
  logic [7:0]  cur_w;
  logic [31:0] cur_rd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_instr();
    req_t r;
    if (iq.size() > 0) begin
      r = iq.pop_front();
      cpu.i_req  = 1'b1;
      cpu.i_addr = r.addr;
    end else begin
      cpu.i_req = 1'b0;
    end
  endtask

  task automatic next_data();
    req_t r;
    if (dq.size() > 0) begin
      r = dq.pop_front();
      cpu.d_req        = 1'b1;
      cpu.d_write      = r.write;
      cpu.d_addr       = r.addr;
      cpu.d_byteenable = r.be;
      cpu.d_wdata      = r.wdata;
    end else begin
      cpu.d_req = 1'b0;
    end
  endtask

  task automatic monitor();
    logic        strobe;
    logic        ack_any;
    logic [33:0] e;
    cycle++;
    strobe  = mem.read | mem.write;
    ack_any = cpu.i_ack | cpu.d_ack;
    check("rw_exclusive", mem.read & mem.write, 1'b0);
    check("ack_exclusive", cpu.i_ack & cpu.d_ack, 1'b0);
    check("stall", cpu.stall, (cpu.i_req | cpu.d_req) & !ack_any);
    check("ack_after_strobe", ack_any, prev_strobe & !strobe);
    if (strobe && !prev_strobe) begin
      if (exp_q.size() == 0 || plan_q.size() == 0) begin
        check("unexpected_txn", 1'b1, 1'b0);
        cur   = '0;
        cur_w = 8'd0;
      end else begin
        cur = exp_q.pop_front();
        {cur_w, cur_rd} = plan_q.pop_front();
        check("txn_start_cycle", cycle, exp_start);
        check("txn_port", dbg_grant, cur[69]);
        check("txn_kind", {mem.write, mem.read}, {cur[68], !cur[68]});
        check("txn_addr", mem.address, cur[67:36]);
        check("txn_be", mem.byteenable, cur[35:32]);
        if (cur[68]) check("txn_wdata", mem.writedata, cur[31:0]);
      end
      held       = {mem.address, mem.read, mem.write, mem.byteenable, mem.writedata};
      strobe_len = 0;
      wait_cnt   = 0;
    end else if (strobe) begin
      check("attr_stable", {mem.address, mem.read, mem.write, mem.byteenable, mem.writedata}, held);
    end
    if (strobe) strobe_len++;
    if (!strobe && prev_strobe) begin
      check("strobe_len", strobe_len, cur[77:70]);
      exp_start = cycle + 2;
    end
    if (ack_any) begin
      if (ack_q.size() == 0) begin
        check("unexpected_ack", 1'b1, 1'b0);
      end else begin
        e = ack_q.pop_front();
        check("ack_port", {cpu.d_ack, cpu.i_ack}, e[33] ? 2'b10 : 2'b01);
        check("ack_err", cpu.bus_err, e[32]);
        check("ack_rdata", e[33] ? cpu.d_rdata : cpu.i_rdata, e[31:0]);
      end
    end
    prev_strobe = strobe;
  endtask

  task automatic drive_slave();
    if (mem.read | mem.write) begin
      mem.waitrequest = (wait_cnt < int'(cur_w));
      mem.readdata    = mem.waitrequest ? $urandom : cur_rd;
      wait_cnt++;
    end else begin
      mem.waitrequest = 1'($urandom_range(0, 1));
      mem.readdata    = $urandom;
    end
  endtask

  task automatic tick();
    logic ia, da;
    @(negedge clk);
    ia = cpu.i_ack;
    da = cpu.d_ack;
    monitor();
    drive_slave();
    if (ia) next_instr();
    if (da) next_data();
  endtask

  // ---------------- reference model + round runner ----------------
  task automatic run_round(input int force_w, input bit use_rd, input logic [31:0] force_rd);
    int          ii;
    int          di;
    int          budget;
    int          w;
    int          len;
    bit          pick_d;
    bit          to;
    req_t        r;
    logic [31:0] rd;
    logic [31:0] ackd;
    ii = 0;
    di = 0;
    while (ii < iq.size() || di < dq.size()) begin
      if (ii < iq.size() && di < dq.size()) pick_d = !last_data_m;
      else                                   pick_d = (di < dq.size());
      if (pick_d) begin r = dq[di]; di++; end
      else        begin r = iq[ii]; ii++; end
      w    = (force_w >= 0) ? force_w : $urandom_range(0, 6);
      rd   = use_rd ? force_rd : $urandom;
      to   = (w >= TMO);
      len  = to ? TMO : w + 1;
      if (to)           ackd = 32'h0;
      else if (r.write) ackd = rdata_m[pick_d];
      else              ackd = rd;
      rdata_m[pick_d] = ackd;
      if (!to) last_data_m = pick_d;
      exp_q.push_back({8'(len), pick_d, r.write, r.addr[31:2], 2'b00, r.be, r.wdata});
      ack_q.push_back({pick_d, to, ackd});
      plan_q.push_back({8'(w), rd});
    end
    exp_start = cycle + 1;
    next_instr();
    next_data();
    budget = 300;
    while (ack_q.size() > 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("round_complete", ack_q.size(), 0);
    repeat (2) tick();
    check("bus_drained", exp_q.size(), 0);
    exp_q.delete();
    ack_q.delete();
    plan_q.delete();
    iq.delete();
    dq.delete();
    cpu.i_req = 1'b0;
    cpu.d_req = 1'b0;
  endtask

  function automatic req_t rand_fetch();
    req_t r;
    r.write = 1'b0;
    r.addr  = $urandom;
    r.be    = 4'hF;
    r.wdata = 32'h0;
    return r;
  endfunction

  function automatic req_t rand_data();
    req_t r;
    r.write = 1'($urandom_range(0, 1));
    r.addr  = $urandom;
    r.be    = 4'($urandom_range(1, 15));
    r.wdata = $urandom;
    return r;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int mode;
    cpu.i_req = 1'b0; cpu.i_addr = '0;
    cpu.d_req = 1'b0; cpu.d_write = 1'b0; cpu.d_addr = '0;
    cpu.d_wdata = '0; cpu.d_byteenable = '0;
    mem.waitrequest = 1'b0; mem.readdata = '0;
    rdata_m[0] = '0; rdata_m[1] = '0;
    last_data_m = 1'b0; prev_strobe = 1'b0; cycle = 0; exp_start = 0;
    strobe_len = 0; wait_cnt = 0; cur = '0; held = '0; cur_w = '0; cur_rd = '0;

    repeat (2) @(negedge clk);
    check("reset_bus_outputs",
          {mem.address, mem.read, mem.write, mem.writedata, mem.byteenable}, '0);
    check("reset_cpu_outputs",
          {cpu.i_rdata, cpu.i_ack, cpu.d_rdata, cpu.d_ack, cpu.bus_err, cpu.stall}, '0);
    check("reset_state", {dbg_state, dbg_grant}, {IDLE, INSTR});
    reset = 1'b0;
    repeat (2) tick();

    // first tie after reset goes to data
    iq.push_back(rand_fetch());
    dq.push_back(rand_data());
    run_round(0, 1'b0, 32'h0);

    // back-to-back ties alternate
    repeat (3) iq.push_back(rand_fetch());
    repeat (3) dq.push_back(rand_data());
    run_round(0, 1'b0, 32'h0);

    // single fetch from the reset vector
    iq.push_back(req_t'{1'b0, 32'hBFC00000, 4'hF, 32'h0});
    run_round(0, 1'b1, 32'h24020005);

    // unaligned store with three wait states
    dq.push_back(req_t'{1'b1, 32'h00001003, 4'h8, 32'hAB000000});
    run_round(3, 1'b0, 32'h0);

    // stuck waitrequest times out, then a normal transfer follows
    iq.push_back(rand_fetch());
    run_round(20, 1'b0, 32'h0);
    dq.push_back(req_t'{1'b0, 32'h00002000, 4'hF, 32'h0});
    run_round(1, 1'b1, 32'hCAFEF00D);

    for (int rnd = 0; rnd < 40; rnd++) begin
      mode = $urandom_range(1, 3);
      if (mode[0]) repeat ($urandom_range(1, 2)) iq.push_back(rand_fetch());
      if (mode[1]) repeat ($urandom_range(1, 2)) dq.push_back(rand_data());
      run_round(-1, 1'b0, 32'h0);
    end

    // reset in the middle of a bus transfer
    cpu.i_req = 1'b1; cpu.i_addr = 32'h00400000;
    cpu.d_req = 1'b1; cpu.d_write = 1'b1; cpu.d_addr = 32'h00003000;
    cpu.d_byteenable = 4'hF; cpu.d_wdata = 32'h12345678;
    mem.waitrequest = 1'b1;
    @(negedge clk);
    check("rst_mid_strobe_on", mem.read | mem.write, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_strobe_drop", {mem.read, mem.write}, 2'b00);
    check("rst_mid_state", dbg_state, IDLE);
    check("rst_mid_bus_outputs",
          {mem.address, mem.writedata, mem.byteenable}, '0);
    repeat (3) begin
      @(negedge clk);
      check("rst_mid_no_ack", {cpu.i_ack, cpu.d_ack}, 2'b00);
    end
    cpu.i_req = 1'b0;
    cpu.d_req = 1'b0;
    reset = 1'b0;
    prev_strobe = 1'b0;
    last_data_m = 1'b0;
    rdata_m[0] = '0;
    rdata_m[1] = '0;
    repeat (2) tick();

    iq.push_back(rand_fetch());
    dq.push_back(rand_data());
    run_round(0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
